// File: rtl/aes_round_sequencer_pkg.sv
// Shared AES types and GF(2^8) helpers for the iterative round sequencer.
// S-boxes are computed (field inverse + affine map) rather than tabulated.
package AESDefinitions;

  localparam int NR_AES128 = 10;
  localparam int KEY_IDX_W = 4;

  typedef logic [127:0] state_t;

  typedef enum logic [2:0] {IDLE, KEYLOAD, ROUND, FINAL, DONE} seq_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; zero maps to zero as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_round_sequencer_datapath.sv
// Combinational shared AES round: forward or inverse, with the column mix
// bypassed on the final round. Byte order is FIPS-197 (byte 0 in bits 127:120).
module aes_round_datapath
  import AESDefinitions::*;
(
  input  state_t s,
  input  state_t key,
  input  logic   decrypt,
  input  logic   final_round,
  output state_t next_s
);

  logic [7:0] sub_b [16];

  // (Inv)ShiftRows and (Inv)SubBytes commute, so both are folded into one byte mux
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      localparam int R       = gi % 4;
      localparam int C       = gi / 4;
      localparam int ENC_SRC = R + 4 * ((C + R) % 4);
      localparam int DEC_SRC = R + 4 * ((C - R + 4) % 4);
      assign sub_b[gi] = decrypt ? inv_sbox(s[127-8*DEC_SRC -: 8])
                                 : sbox(s[127-8*ENC_SRC -: 8]);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      logic [31:0] col, key_col, enc_col, dec_col;
      assign col     = {sub_b[4*gi], sub_b[4*gi+1], sub_b[4*gi+2], sub_b[4*gi+3]};
      assign key_col = key[127-32*gi -: 32];
      assign enc_col = (final_round ? col : mix_col(col)) ^ key_col;
      assign dec_col = col ^ key_col;
      assign next_s[127-32*gi -: 32] = decrypt ? (final_round ? dec_col : inv_mix_col(dec_col))
                                               : enc_col;
    end
  endgenerate

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES controller: FSM, round counter, round-key index decode and block/result registers.
// Optional AES_SEQ_ABORT_EN adds an abort input that drops the block in flight.
module aes_round_sequencer
  import AESDefinitions::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic                 clock,
  input  logic                 reset_n,
`ifdef AES_SEQ_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_decrypt,
  input  state_t               in_data,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  state_t               round_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output state_t               out_data,
  output logic                 busy
);

  localparam logic [KEY_IDX_W-1:0] NR_IDX = KEY_IDX_W'(NR);

  seq_state_e             fsm_reg;
  logic [KEY_IDX_W-1:0]   rnd_reg;
  logic                   dec_reg;
  state_t                 blk_reg;
  state_t                 rnd_out;
  logic                   abort_hit;

`ifdef AES_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign in_ready = (fsm_reg == IDLE);
  assign busy     = (fsm_reg == ROUND) || (fsm_reg == FINAL) || (fsm_reg == DONE);

  always_comb begin
    key_idx = '0;
    case (fsm_reg)
      KEYLOAD: key_idx = NR_IDX;
      ROUND:   key_idx = dec_reg ? (NR_IDX - rnd_reg) : rnd_reg;
      FINAL:   key_idx = dec_reg ? '0 : NR_IDX;
      default: key_idx = '0;
    endcase
  end

  aes_round_datapath u_datapath (
    .s           (blk_reg),
    .key         (round_key),
    .decrypt     (dec_reg),
    .final_round (fsm_reg == FINAL),
    .next_s      (rnd_out)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fsm_reg   <= IDLE;
      rnd_reg   <= '0;
      dec_reg   <= 1'b0;
      blk_reg   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (abort_hit && fsm_reg != IDLE) begin
      fsm_reg   <= IDLE;
      rnd_reg   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (in_valid) begin
            dec_reg <= in_decrypt;
            rnd_reg <= KEY_IDX_W'(1);
            // decrypt needs key[NR] first, which costs one extra fetch cycle
            if (in_decrypt) begin
              blk_reg <= in_data;
              fsm_reg <= KEYLOAD;
            end else begin
              blk_reg <= in_data ^ round_key;
              fsm_reg <= ROUND;
            end
          end
        end
        KEYLOAD: begin
          blk_reg <= blk_reg ^ round_key;
          fsm_reg <= ROUND;
        end
        ROUND: begin
          blk_reg <= rnd_out;
          rnd_reg <= rnd_reg + KEY_IDX_W'(1);
          if (rnd_reg == NR_IDX - KEY_IDX_W'(1)) fsm_reg <= FINAL;
        end
        FINAL: begin
          out_data  <= rnd_out;
          out_valid <= 1'b1;
          rnd_reg   <= '0;
          fsm_reg   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm_reg   <= IDLE;
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

endmodule
